analog_interface: RTL and testbench
===================================

# analog_interface

Capture-control front end of the digital oscilloscope. It generates the ADC sample clock, decimates the sample rate, and drives the write port of the 512-entry circular trace RAM. It arms and detects the trigger on channel 1 or channel 2, stores `trig_pos` pre-trigger and `512 - trig_pos` post-trigger samples, then reports completion to the register block. It sits between the register/command block (`trig_cfg`, `decimator`, `trig_pos`) and the ADC plus capture RAMs.

## Interface
Parameters:
- ENTRIES, 512: trace RAM depth; `addr` width is log2(ENTRIES) = 9.
- AUTO_TIMEOUT, 512: samples spent in ARMED before auto mode forces a trigger.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- trig1  in  1  channel 1 trigger comparator output; asynchronous.
- trig2  in  1  channel 2 trigger comparator output; asynchronous.
- decimator  in  4  store one sample every 2^decimator ADC samples.
- trig_cfg  in  8  trigger configuration:
  - [5] cap_done: while 1, a new capture is held off.
  - [4] edge: 1 = rising, 0 = falling.
  - [3:2] mode: 00 stop, 01 normal, 10 auto, 11 normal.
  - [1:0] src: bit0 = 0 selects trig1, 1 selects trig2; bit1 ignored.
  - [7:6] ignored.
- trig_pos  in  9  number of pre-trigger samples.
- adc_clk  out  1  ADC conversion clock, clk/2.
- en  out  1  trace RAM enable.
- we  out  1  trace RAM write enable.
- addr  out  9  trace RAM write address.
- trace_end  out  9  address of the last sample of the completed capture.
- set_cap_done  out  1  one-cycle pulse telling the register block to set cap_done.

## Operation
- `adc_clk` toggles every clk. Sample tick is the cycle in which `adc_clk` goes 0→1.
- Decimation counter: 16 bits, advances on each sample tick.
  - A store occurs when the counter's low `decimator` bits are all zero.
  - The counter clears at the start of each capture.
- Store cycle: `en = we = 1` for exactly one clk with the current `addr`. `addr` increments modulo 512 after the store.
- Trigger path:
  - Selected source passes through a 2-flop synchronizer, then a registered previous value.
  - An edge is detected when prev/current match the configured polarity.
- States:
  - IDLE: entered after reset. Go to PRETRIG when mode != 00 and cap_done = 0. Latch `trig_pos`, clear sample count and decimation counter; `addr` is not reset.
  - PRETRIG: `armed = 0`. Count stores. Go to ARMED when count ≥ latched `trig_pos` (immediately if `trig_pos = 0`).
  - ARMED: `armed = 1`; stores continue, overwriting circularly. On a detected edge, go to POSTTRIG with `triggered = 1` and the post count cleared. In auto mode, force the same transition after AUTO_TIMEOUT stores without an edge.
  - POSTTRIG: `triggered = 1`. After `512 - trig_pos` stores (the last store included), go to DONE.
  - DONE: one cycle.
    - `trace_end` ← address of the final store.
    - `set_cap_done` = 1.
    - `triggered` and `armed` clear.
    - Go to IDLE.
- If mode becomes 00 in PRETRIG or ARMED, return to IDLE at the next cycle. No `set_cap_done` is issued.
- An edge seen outside ARMED is ignored.

## Timing
- Reset values:
  - Outputs: `adc_clk 0`, `en 0`, `we 0`, `addr 0`, `trace_end 0`, `set_cap_done 0`.
  - Internal: `armed 0`, `triggered 0`, state IDLE, synchronizer flops 0.
- Trigger latency: `triggered` rises no more than 3 clk after the qualifying input edge reaches the port (2 sync + 1 detect).
- `en`/`we` assert at most once per 2 clk (once per 2·2^decimator clk when decimated).
- `set_cap_done` rises in the clk after the final post-trigger store.
- IDLE re-evaluates cap_done from the cycle after DONE, so the register block must set cap_done within one clk to hold off the next capture.
- `trace_end` holds until the next DONE.
- Reset mid-capture: everything returns to reset values at the next clk edge, with no `set_cap_done`.

## Test plan
- `trig_cfg = 0x14` (rising, normal, trig1), `decimator = 2`, `trig_pos = 0x0A1`; release reset.
  - `armed` rises after 0xA1 stores, spaced 8 clk apart.
  - Raise trig1 → `triggered = 1` within 4 clk.
- Continue the capture above:
  - Exactly 0x15F further stores occur.
  - `set_cap_done` then pulses for one clk.
  - `triggered = 0` the next clk, and `trace_end` equals the last `addr` written.
- After done, drop trig1 and set `trig_pos = 0x013` with cap_done still 0:
  - A new capture starts and `armed` rises after 0x13 stores.
  - Raise trig1 → `triggered = 1` within 4 clk.
- `trig_cfg = 0x05` (falling edge, normal, trig2) with trig2 high, then drop it:
  - `triggered` rises.
  - Toggling trig1 has no effect.
- Auto mode `0x08` with triggers idle: a forced trigger occurs after 512 armed stores, then 512 - `trig_pos` stores follow and `set_cap_done` pulses.
- cap_done bit = 1 or mode 00: no `en`/`we` activity and `armed` stays 0. Apply reset while in POSTTRIG: all outputs return to 0.

Source files
------------

// File: rtl/analog_interface.sv
// -----------------------------------------------------------------------------
// analog_interface
// Capture-control front end of the oscilloscope. Generates the ADC sample
// clock (clk/2), decimates the sample stream, drives the write port of the
// circular trace RAM, arms/detects the trigger on channel 1 or 2 and reports
// capture completion to the register block.
//
// Ports
//   clk           in   system clock (only clock)
//   rst           in   synchronous active-high reset
//   trig1/trig2   in   asynchronous trigger comparator outputs
//   decimator     in   store one sample every 2^decimator ADC samples
//   trig_cfg      in   [5] cap_done, [4] edge (1 rising), [3:2] mode, [0] src
//   trig_pos      in   number of pre-trigger samples
//   adc_clk       out  ADC conversion clock
//   en / we       out  trace RAM enable / write enable (one-clk store pulse)
//   addr          out  trace RAM write address
//   trace_end     out  address of the last sample of the completed capture
//   set_cap_done  out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module analog_interface #(
    parameter int ENTRIES      = 512,
    parameter int AUTO_TIMEOUT = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trig1,
    input  logic                       trig2,
    input  logic [3:0]                 decimator,
    input  logic [7:0]                 trig_cfg,
    input  logic [$clog2(ENTRIES)-1:0] trig_pos,
    output logic                       adc_clk,
    output logic                       en,
    output logic                       we,
    output logic [$clog2(ENTRIES)-1:0] addr,
    output logic [$clog2(ENTRIES)-1:0] trace_end,
    output logic                       set_cap_done
);

    localparam int AW = $clog2(ENTRIES);
    // Store counter must hold the larger of ENTRIES and AUTO_TIMEOUT.
    localparam int CW = $clog2(((ENTRIES > AUTO_TIMEOUT) ? ENTRIES : AUTO_TIMEOUT) + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRETRIG  = 3'd1,
        S_ARMED    = 3'd2,
        S_POSTTRIG = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            adc_clk_q;
    logic [15:0]     dec_q, dec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   pos_q, pos_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   trace_end_q, trace_end_d;
    logic            en_q, en_d;
    logic            set_cap_done_q, set_cap_done_d;
    logic            armed_q, armed_d;
    logic            triggered_q, triggered_d;

    logic            mode_stop_s, mode_auto_s, trig_sel_s, tick_s, capturing_s;
    logic            store_s, edge_s, start_s;
    logic [15:0]     dec_mask_s;
    logic [CW-1:0]   cnt_inc_s, post_target_s;
    logic            unused_cfg_s;

    assign unused_cfg_s  = ^{trig_cfg[7:6], trig_cfg[1]};
    assign mode_stop_s   = (trig_cfg[3:2] == 2'b00);
    assign mode_auto_s   = (trig_cfg[3:2] == 2'b10);
    assign trig_sel_s    = trig_cfg[0] ? trig2 : trig1;
    // adc_clk rises at the end of every cycle in which it is currently low.
    assign tick_s        = ~adc_clk_q;
    assign dec_mask_s    = (16'd1 << decimator) - 16'd1;
    assign capturing_s   = (state_q == S_PRETRIG) || (state_q == S_ARMED) ||
                           (state_q == S_POSTTRIG);
    // Suppressing the store when mode drops to stop keeps a pending write out of IDLE.
    assign store_s       = tick_s && capturing_s && !mode_stop_s &&
                           ((dec_q & dec_mask_s) == 16'd0);
    assign edge_s        = trig_cfg[4] ? (sync2_q & ~prev_q) : (~sync2_q & prev_q);
    // Store count including the store (if any) completing in this cycle.
    assign cnt_inc_s     = cnt_q + {{(CW-1){1'b0}}, en_q};
    assign post_target_s = CW'(ENTRIES) - CW'(pos_q);
    assign start_s       = (state_q == S_IDLE) && (state_d == S_PRETRIG);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic of the capture sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!mode_stop_s && !trig_cfg[5]) state_d = S_PRETRIG;
                else                              state_d = S_IDLE;
            end
            S_PRETRIG: begin
                if (mode_stop_s)                   state_d = S_IDLE;
                else if (cnt_inc_s >= CW'(pos_q))  state_d = S_ARMED;
                else                               state_d = S_PRETRIG;
            end
            S_ARMED: begin
                if (mode_stop_s)                   state_d = S_IDLE;
                else if (edge_s)                   state_d = S_POSTTRIG;
                else if (mode_auto_s && (cnt_inc_s >= CW'(AUTO_TIMEOUT)))
                                                   state_d = S_POSTTRIG;
                else                               state_d = S_ARMED;
            end
            S_POSTTRIG: begin
                if (cnt_inc_s >= post_target_s)    state_d = S_DONE;
                else                               state_d = S_POSTTRIG;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of registered outputs and status flags.
    always_comb begin
        en_d           = store_s;
        armed_d        = (state_d == S_ARMED);
        triggered_d    = (state_d == S_POSTTRIG);
        set_cap_done_d = (state_q == S_POSTTRIG) && (state_d == S_DONE);
    end

    // Next values of the datapath registers.
    always_comb begin
        dec_d       = dec_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        addr_d      = addr_q;
        trace_end_d = trace_end_q;
        if (start_s)     dec_d = 16'd0;
        else if (tick_s) dec_d = dec_q + 16'd1;
        else             dec_d = dec_q;
        // Store count restarts on every state change; each phase counts its own stores.
        if (state_d != state_q) cnt_d = '0;
        else if (capturing_s)   cnt_d = cnt_inc_s;
        else                    cnt_d = cnt_q;
        if (start_s) pos_d = trig_pos;
        else         pos_d = pos_q;
        // Address advances after the store that used it.
        if (en_q) addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
        else      addr_d = addr_q;
        if (set_cap_done_d) trace_end_d = addr_q;
        else                trace_end_d = trace_end_q;
    end

    // Datapath, synchronizer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_clk_q      <= 1'b0;
            dec_q          <= 16'd0;
            cnt_q          <= '0;
            pos_q          <= '0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            prev_q         <= 1'b0;
            addr_q         <= '0;
            trace_end_q    <= '0;
            en_q           <= 1'b0;
            set_cap_done_q <= 1'b0;
            armed_q        <= 1'b0;
            triggered_q    <= 1'b0;
        end else begin
            adc_clk_q      <= ~adc_clk_q;
            dec_q          <= dec_d;
            cnt_q          <= cnt_d;
            pos_q          <= pos_d;
            sync1_q        <= trig_sel_s;
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            addr_q         <= addr_d;
            trace_end_q    <= trace_end_d;
            en_q           <= en_d;
            set_cap_done_q <= set_cap_done_d;
            armed_q        <= armed_d;
            triggered_q    <= triggered_d;
        end
    end

    assign adc_clk      = adc_clk_q;
    assign en           = en_q;
    assign we           = en_q;
    assign addr         = addr_q;
    assign trace_end    = trace_end_q;
    assign set_cap_done = set_cap_done_q;

endmodule

// File: tb/tb_analog_interface.sv
// -----------------------------------------------------------------------------
// tb_analog_interface
// Directed self-checking bench for analog_interface: a linear sequence of
// captures (normal rising/trig1, falling/trig2, auto), hold-off by cap_done
// and stop mode, and reset during post-trigger.
// -----------------------------------------------------------------------------
module tb_analog_interface;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig1, trig2;
    logic [3:0] decimator;
    logic [7:0] trig_cfg;
    logic [8:0] trig_pos;
    logic       adc_clk, en, we, set_cap_done;
    logic [8:0] addr, trace_end;

    analog_interface #(.ENTRIES(512), .AUTO_TIMEOUT(512)) dut (
        .clk(clk), .rst(rst), .trig1(trig1), .trig2(trig2),
        .decimator(decimator), .trig_cfg(trig_cfg), .trig_pos(trig_pos),
        .adc_clk(adc_clk), .en(en), .we(we), .addr(addr),
        .trace_end(trace_end), .set_cap_done(set_cap_done)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [8:0] exp_addr = 9'd0;
    logic [8:0] last_addr = 9'd0;
    logic [8:0] tend_hold;
    int         n_pre, n_armed, n_post, last_store, min_gap, max_gap;
    bit         have_last, seen_armed, ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_counts();
        n_pre = 0; n_armed = 0; n_post = 0;
        have_last = 1'b0; min_gap = 1000000; max_gap = 0; seen_armed = 1'b0;
    endtask

    // One clock: sample at the falling edge and score any store seen.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (dut.armed_q === 1'b1) seen_armed = 1'b1;
        if (en === 1'b1) begin
            check("store_we_addr", {22'd0, we, addr}, {22'd0, 1'b1, exp_addr});
            if (have_last) begin
                if (cyc - last_store < min_gap) min_gap = cyc - last_store;
                if (cyc - last_store > max_gap) max_gap = cyc - last_store;
            end
            have_last  = 1'b1;
            last_store = cyc;
            last_addr  = exp_addr;
            exp_addr   = exp_addr + 9'd1;
            if (dut.triggered_q === 1'b1)  n_post++;
            else if (dut.armed_q === 1'b1) n_armed++;
            else                           n_pre++;
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return (dut.armed_q === 1'b1);
            1:       return (dut.triggered_q === 1'b1);
            2:       return (set_cap_done === 1'b1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_until(input int which, input int limit, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (cond(which)) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; trig1 = 1'b0; trig2 = 1'b0;
        trig_cfg = 8'h14; decimator = 4'd2; trig_pos = 9'h0A1;
        clear_counts();
        repeat (3) step();
        check("rst_adc_clk", {31'd0, adc_clk}, 32'd0);
        check("rst_en_we", {30'd0, en, we}, 32'd0);
        check("rst_addr", {23'd0, addr}, 32'd0);
        check("rst_trace_end", {23'd0, trace_end}, 32'd0);
        check("rst_set_cap_done", {31'd0, set_cap_done}, 32'd0);
        check("rst_armed_trig", {30'd0, dut.armed_q, dut.triggered_q}, 32'd0);

        // Capture 1: rising, normal, trig1, decimate by 4, 0xA1 pre-trigger.
        rst = 1'b0;
        clear_counts();
        run_until(0, 3000, ok);
        check("cap1_armed_reached", {31'd0, ok}, 32'd1);
        check("cap1_pre_stores", 32'(n_pre), 32'h0A1);
        check("cap1_gap_min", 32'(min_gap), 32'd8);
        check("cap1_gap_max", 32'(max_gap), 32'd8);
        trig1 = 1'b1;
        run_until(1, 4, ok);
        check("cap1_trig_latency", {31'd0, ok}, 32'd1);
        run_until(2, 4000, ok);
        check("cap1_done_reached", {31'd0, ok}, 32'd1);
        check("cap1_post_stores", 32'(n_post), 32'h15F);
        check("cap1_armed_stores", 32'(n_armed), 32'd0);
        check("cap1_gap_max_total", 32'(max_gap), 32'd8);
        check("cap1_trace_end", {23'd0, trace_end}, {23'd0, last_addr});
        check("cap1_trace_end_wrap", {23'd0, trace_end}, 32'h1FF);
        tend_hold = last_addr;
        trig_pos = 9'h013; trig1 = 1'b0;
        step();
        check("cap1_done_pulse_len", {31'd0, set_cap_done}, 32'd0);
        check("cap1_triggered_clear", {31'd0, dut.triggered_q}, 32'd0);

        // Capture 2 starts on its own: cap_done still 0.
        clear_counts();
        run_until(0, 1000, ok);
        check("cap2_armed_reached", {31'd0, ok}, 32'd1);
        check("cap2_pre_stores", 32'(n_pre), 32'h013);
        check("cap2_trace_end_hold", {23'd0, trace_end}, {23'd0, tend_hold});
        trig1 = 1'b1;
        run_until(1, 4, ok);
        check("cap2_trig_latency", {31'd0, ok}, 32'd1);
        run_until(2, 5000, ok);
        check("cap2_done_reached", {31'd0, ok}, 32'd1);
        check("cap2_post_stores", 32'(n_post), 32'h1ED);
        check("cap2_trace_end", {23'd0, trace_end}, {23'd0, last_addr});

        // Capture 3: falling edge on trig2, no decimation, no pre-trigger.
        trig_cfg = 8'h05; trig2 = 1'b1; trig1 = 1'b0;
        trig_pos = 9'h000; decimator = 4'd0;
        clear_counts();
        run_until(0, 20, ok);
        check("cap3_armed_reached", {31'd0, ok}, 32'd1);
        repeat (6) step();
        trig1 = 1'b1; repeat (2) step();
        trig1 = 1'b0; repeat (2) step();
        trig1 = 1'b1; repeat (2) step();
        trig1 = 1'b0; repeat (4) step();
        check("cap3_trig1_ignored", {30'd0, dut.armed_q, dut.triggered_q}, 32'd2);
        trig2 = 1'b0;
        run_until(1, 4, ok);
        check("cap3_fall_trig_latency", {31'd0, ok}, 32'd1);
        run_until(2, 2000, ok);
        check("cap3_done_reached", {31'd0, ok}, 32'd1);
        check("cap3_post_stores", 32'(n_post), 32'd512);
        check("cap3_gap_min", 32'(min_gap), 32'd2);

        // Capture 4: auto mode with idle triggers.
        trig_cfg = 8'h08; trig_pos = 9'h040;
        clear_counts();
        run_until(0, 300, ok);
        check("auto_armed_reached", {31'd0, ok}, 32'd1);
        check("auto_pre_stores", 32'(n_pre), 32'h040);
        run_until(1, 2000, ok);
        check("auto_forced_trigger", {31'd0, ok}, 32'd1);
        check("auto_armed_stores", 32'(n_armed), 32'd512);
        run_until(2, 2000, ok);
        check("auto_done_reached", {31'd0, ok}, 32'd1);
        check("auto_post_stores", 32'(n_post), 32'd448);

        // Hold-off: cap_done set, then stop mode.
        trig_cfg = 8'h34;
        clear_counts();
        repeat (40) step();
        check("holdoff_capdone_stores", 32'(n_pre + n_armed + n_post), 32'd0);
        check("holdoff_capdone_armed", {31'd0, seen_armed}, 32'd0);
        trig_cfg = 8'h10;
        clear_counts();
        repeat (40) step();
        check("holdoff_stop_stores", 32'(n_pre + n_armed + n_post), 32'd0);
        check("holdoff_stop_armed", {31'd0, seen_armed}, 32'd0);

        // Reset while in POSTTRIG.
        trig_cfg = 8'h14; trig_pos = 9'h000; decimator = 4'd0; trig1 = 1'b0;
        clear_counts();
        run_until(0, 20, ok);
        check("rstpost_armed_reached", {31'd0, ok}, 32'd1);
        repeat (4) step();
        trig1 = 1'b1;
        run_until(1, 4, ok);
        check("rstpost_trig_latency", {31'd0, ok}, 32'd1);
        repeat (5) step();
        check("rstpost_in_posttrig", {31'd0, dut.triggered_q}, 32'd1);
        rst = 1'b1;
        step();
        check("rstpost_adc_clk", {31'd0, adc_clk}, 32'd0);
        check("rstpost_en_we", {30'd0, en, we}, 32'd0);
        check("rstpost_addr", {23'd0, addr}, 32'd0);
        check("rstpost_trace_end", {23'd0, trace_end}, 32'd0);
        check("rstpost_set_cap_done", {31'd0, set_cap_done}, 32'd0);
        check("rstpost_armed_trig", {30'd0, dut.armed_q, dut.triggered_q}, 32'd0);
        exp_addr = 9'd0;
        trig_cfg = 8'h10;
        rst = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
